// File: rtl/idma_legalizer_req_scheduler_pkg.sv
// idma_legalizer_req_scheduler_pkg: shared types for the legalizer request scheduler
// Contents: sched_state_e, the arbitration FSM state (ARB = free to pick, HOLD = grant locked).
package idma_legalizer_req_scheduler_pkg;

    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_HOLD = 1'b1
    } sched_state_e;

endpackage

// File: rtl/idma_sched_credit_counter.sv
// idma_sched_credit_counter: per-port outstanding-transfer credit counter
// Ports: clk_i/rst_ni clock and async active-low reset; inc_i grant issued; dec_i transfer
// completed; clear_i kill (wins over inc/dec); cnt_o current in-flight count.
module idma_sched_credit_counter #(
    parameter int unsigned MaxCount = 4,
    parameter int unsigned CntWidth = $clog2(MaxCount + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                inc_i,
    input  logic                dec_i,
    input  logic                clear_i,
    output logic [CntWidth-1:0] cnt_o
);

    logic [CntWidth-1:0] cnt_d, cnt_q;

    // Simultaneous inc and dec cancel; a decrement at zero saturates.
    always_comb begin
        cnt_d = clear_i                              ? '0 :
                (inc_i && !dec_i)                    ? cnt_q + 1'b1 :
                (dec_i && !inc_i && cnt_q != '0)     ? cnt_q - 1'b1 : cnt_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

`ifndef SYNTHESIS
    assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(dec_i && !inc_i && !clear_i && cnt_q == '0));
    assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(inc_i && !dec_i && !clear_i && cnt_q == CntWidth'(MaxCount)));
`endif

endmodule

// File: rtl/idma_legalizer_req_scheduler.sv
// idma_legalizer_req_scheduler: round-robin share of one legalizer 1D-request input with per-port credits
// Ports: req_i/valid_i/ready_o per-port request streams; req_o/valid_o/ready_i/port_id_o granted
// stream to the legalizer; flush_i blocks new grants; kill_i clears credits and lock;
// done_valid_i/done_port_i completion feedback; busy_o port has transfers in flight.
// Optional: define IDMA_SCHED_PRIO_EN to add prio_i; eligible prio ports are then searched first.
module idma_legalizer_req_scheduler
    import idma_legalizer_req_scheduler_pkg::*;
#(
    parameter  int unsigned NumPorts       = 2,
    parameter  int unsigned MaxOutstanding = 4,
    parameter  type         idma_req_t     = logic,
    localparam int unsigned PortIdWidth    = (NumPorts > 1) ? $clog2(NumPorts) : 1,
    localparam int unsigned CntWidth       = $clog2(MaxOutstanding + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  idma_req_t              req_i [NumPorts],
    input  logic [NumPorts-1:0]    valid_i,
    output logic [NumPorts-1:0]    ready_o,
    output idma_req_t              req_o,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [PortIdWidth-1:0] port_id_o,
    input  logic                   flush_i,
    input  logic                   kill_i,
    input  logic                   done_valid_i,
    input  logic [PortIdWidth-1:0] done_port_i,
`ifdef IDMA_SCHED_PRIO_EN
    input  logic [NumPorts-1:0]    prio_i,
`endif
    output logic [NumPorts-1:0]    busy_o
);

    sched_state_e           lock_d, lock_q;
    logic [PortIdWidth-1:0] sel_d, sel_q, rr_d, rr_q, sel, pick;
    logic [CntWidth-1:0]    cnt [NumPorts];
    logic [NumPorts-1:0]    elig, cand, inc, dec;
    logic                   hs;

    // First set bit of c at or after start, wrapping; scanned backwards so the nearest wins.
    function automatic logic [PortIdWidth-1:0] rr_pick(input logic [NumPorts-1:0] c,
                                                       input logic [PortIdWidth-1:0] start);
        int unsigned idx;
        rr_pick = start;
        for (int k = NumPorts - 1; k >= 0; k--) begin
            idx = (int'(start) + k) % NumPorts;
            if (c[idx]) rr_pick = PortIdWidth'(idx);
        end
    endfunction

    for (genvar i = 0; i < NumPorts; i++) begin : g_port
        // Registered counts only: a same-cycle completion does not free a credit yet.
        assign elig[i]    = valid_i[i] && cnt[i] < CntWidth'(MaxOutstanding);
        assign inc[i]     = hs && sel == PortIdWidth'(i);
        assign dec[i]     = done_valid_i && done_port_i == PortIdWidth'(i);
        assign ready_o[i] = inc[i];
        assign busy_o[i]  = cnt[i] != '0;

        idma_sched_credit_counter #(
            .MaxCount (MaxOutstanding),
            .CntWidth (CntWidth)
        ) i_credit (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .inc_i   (inc[i]),
            .dec_i   (dec[i]),
            .clear_i (kill_i),
            .cnt_o   (cnt[i])
        );

`ifndef SYNTHESIS
        assert property (@(posedge clk_i) disable iff (!rst_ni)
            valid_i[i] && !ready_o[i] |=> $stable(req_i[i]) && valid_i[i]);
`endif
    end

`ifdef IDMA_SCHED_PRIO_EN
    assign cand = |(elig & prio_i) ? (elig & prio_i) : elig;
`else
    assign cand = elig;
`endif

    assign pick = rr_pick(cand, rr_q);

    always_comb begin
        sel       = (lock_q == ST_HOLD) ? sel_q : pick;
        valid_o   = (lock_q == ST_HOLD) || (!flush_i && |cand);
        hs        = valid_o && ready_i;
        req_o     = valid_o ? req_i[sel] : '0;
        port_id_o = valid_o ? sel : '0;
        lock_d    = (!kill_i && valid_o && !ready_i) ? ST_HOLD : ST_ARB;
        sel_d     = (valid_o && !ready_i) ? sel : sel_q;
        // rr advances on any handshake, including one in a kill cycle.
        rr_d      = !hs ? rr_q : (sel == PortIdWidth'(NumPorts - 1)) ? '0 : sel + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q <= ST_ARB;
            sel_q  <= '0;
            rr_q   <= '0;
        end else begin
            lock_q <= lock_d;
            sel_q  <= sel_d;
            rr_q   <= rr_d;
        end
    end

`ifndef SYNTHESIS
    assert property (@(posedge clk_i) disable iff (!rst_ni)
        valid_o && !ready_i && !kill_i |=> valid_o && $stable(port_id_o));
    assert property (@(posedge clk_i) disable iff (!rst_ni)
        done_valid_i |-> 32'(done_port_i) < NumPorts);
`endif

endmodule
